mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: the MEM stage of the pipeline. It turns load/store slots from EX/MEM into
// single-word data-memory requests and registers the MEM/WB results.
//   Pipeline in : Valid_IN, ALU_Control_IN, ALU_result_IN (address or result), MemWriteData_IN (rt),
//                 WriteRegister_IN, RegWrite_IN, MemRead_IN, MemWrite_IN
//   Pipeline out: Stall_OUT (comb), Valid_OUT, RegWrite_OUT, WriteRegister_OUT, WriteData_OUT,
//                 AddrErr_OUT, BusErr_OUT (all registered)
//   Memory port : dm_req, dm_we, dm_addr, dm_be, dm_wdata (registered); dm_rdata, dm_ack (in)
// The memory bus is big-endian: byte offset 0 is lane [31:24] and maps to dm_be[3].
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Valid_IN,
  input  logic [5:0]        ALU_Control_IN,
  input  logic [ADDR_W-1:0] ALU_result_IN,
  input  logic [31:0]       MemWriteData_IN,
  input  logic [4:0]        WriteRegister_IN,
  input  logic              RegWrite_IN,
  input  logic              MemRead_IN,
  input  logic              MemWrite_IN,
  output logic              Stall_OUT,
  output logic              Valid_OUT,
  output logic              RegWrite_OUT,
  output logic [4:0]        WriteRegister_OUT,
  output logic [31:0]       WriteData_OUT,
  output logic              AddrErr_OUT,
  output logic              BusErr_OUT,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ack
);

  localparam logic [5:0] OpLb   = 6'b100001;
  localparam logic [5:0] OpLbu  = 6'b101010;
  localparam logic [5:0] OpLh   = 6'b101011;
  localparam logic [5:0] OpLhu  = 6'b101100;
  localparam logic [5:0] OpLw   = 6'b111101;
  localparam logic [5:0] OpLl   = 6'b101000;
  localparam logic [5:0] OpLwc1 = 6'b110101;
  localparam logic [5:0] OpLwl  = 6'b101101;
  localparam logic [5:0] OpLwr  = 6'b101110;
  localparam logic [5:0] OpSb   = 6'b101111;
  localparam logic [5:0] OpSh   = 6'b110000;
  localparam logic [5:0] OpSw   = 6'b110001;
  localparam logic [5:0] OpSc   = 6'b110110;
  localparam logic [5:0] OpSwl  = 6'b110010;
  localparam logic [5:0] OpSwr  = 6'b110011;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_valid, w_valid_d;
  logic              r_regwrite, w_regwrite_d;
  logic [4:0]        r_wreg, w_wreg_d;
  logic [31:0]       r_wdata, w_wdata_d;
  logic              r_addrerr, w_addrerr_d;
  logic              r_buserr, w_buserr_d;
  logic              r_dm_req, w_dm_req_d;
  logic              r_dm_we, w_dm_we_d;
  logic [ADDR_W-1:0] r_dm_addr, w_dm_addr_d;
  logic [3:0]        r_dm_be, w_dm_be_d;
  logic [31:0]       r_dm_wdata, w_dm_wdata_d;

  logic [1:0]  w_off;
  logic [31:0] w_res;
  logic [31:0] w_old;
  logic        w_mem_op;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata;
  logic [7:0]  w_lane;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;
  logic        w_stall;

  assign w_off     = ALU_result_IN[1:0];
  assign w_res     = 32'(ALU_result_IN);
  assign w_old     = MemWriteData_IN;
  assign w_mem_op  = Valid_IN & (MemRead_IN | MemWrite_IN);
  assign w_timeout = (r_cnt == CntLast) & ~dm_ack;

  always_comb begin
    w_misalign = 1'b0;
    case (ALU_Control_IN)
      OpLh, OpLhu, OpSh:               w_misalign = w_off[0];
      OpLw, OpLl, OpLwc1, OpSw, OpSc:  w_misalign = (w_off != 2'd0);
      default:                         w_misalign = 1'b0;
    endcase
  end

  // Store lane enables and lane-positioned write data.
  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = MemWriteData_IN;
    case (ALU_Control_IN)
      OpSb: begin
        w_st_be    = 4'b1000 >> w_off;
        w_st_wdata = {4{MemWriteData_IN[7:0]}};
      end
      OpSh: begin
        w_st_be    = w_off[1] ? 4'b0011 : 4'b1100;
        w_st_wdata = {2{MemWriteData_IN[15:0]}};
      end
      OpSwl: begin
        w_st_be    = 4'b1111 >> w_off;
        w_st_wdata = MemWriteData_IN >> {w_off, 3'b000};
      end
      OpSwr: begin
        // ~w_off == 3 - offset
        w_st_be    = 4'b1111 << ~w_off;
        w_st_wdata = MemWriteData_IN << {~w_off, 3'b000};
      end
      default: ;
    endcase
  end

  // Load data extraction; lane o lives at bits [31-8o -: 8].
  always_comb begin
    w_lane    = 8'(dm_rdata >> {~w_off, 3'b000});
    w_half    = w_off[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    w_ld_data = dm_rdata;
    case (ALU_Control_IN)
      OpLb:  w_ld_data = {{24{w_lane[7]}}, w_lane};
      OpLbu: w_ld_data = {24'b0, w_lane};
      OpLh:  w_ld_data = {{16{w_half[15]}}, w_half};
      OpLhu: w_ld_data = {16'b0, w_half};
      OpLwl: begin
        case (w_off)
          2'd0: w_ld_data = dm_rdata;
          2'd1: w_ld_data = {dm_rdata[23:0], w_old[7:0]};
          2'd2: w_ld_data = {dm_rdata[15:0], w_old[15:0]};
          default: w_ld_data = {dm_rdata[7:0], w_old[23:0]};
        endcase
      end
      OpLwr: begin
        case (w_off)
          2'd0: w_ld_data = {w_old[31:8], dm_rdata[31:24]};
          2'd1: w_ld_data = {w_old[31:16], dm_rdata[31:16]};
          2'd2: w_ld_data = {w_old[31:24], dm_rdata[31:8]};
          default: w_ld_data = dm_rdata;
        endcase
      end
      default: w_ld_data = dm_rdata;
    endcase
  end

  // Next-state and registered-output logic. Error flags and Valid default to 0 so that
  // they are single-cycle pulses; the dm_* registers hold unless explicitly loaded.
  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_valid_d    = 1'b0;
    w_regwrite_d = 1'b0;
    w_wreg_d     = r_wreg;
    w_wdata_d    = r_wdata;
    w_addrerr_d  = 1'b0;
    w_buserr_d   = 1'b0;
    w_dm_req_d   = r_dm_req;
    w_dm_we_d    = r_dm_we;
    w_dm_addr_d  = r_dm_addr;
    w_dm_be_d    = r_dm_be;
    w_dm_wdata_d = r_dm_wdata;
    w_stall      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_mem_op && !w_misalign) begin
          w_stall      = 1'b1;
          w_state_d    = StBusy;
          w_cnt_d      = '0;
          w_dm_req_d   = 1'b1;
          w_dm_we_d    = MemWrite_IN;
          w_dm_addr_d  = {ALU_result_IN[ADDR_W-1:2], 2'b00};
          w_dm_be_d    = MemWrite_IN ? w_st_be : 4'b1111;
          w_dm_wdata_d = w_st_wdata;
        end else if (w_mem_op) begin
          w_valid_d   = 1'b1;
          w_addrerr_d = 1'b1;
          w_wreg_d    = WriteRegister_IN;
          w_wdata_d   = w_res;
        end else begin
          w_valid_d    = Valid_IN;
          w_regwrite_d = RegWrite_IN;
          w_wreg_d     = WriteRegister_IN;
          w_wdata_d    = w_res;
        end
      end
      StBusy: begin
        // Inputs are held constant while stalled, so they still describe this request.
        if (dm_ack) begin
          w_state_d    = StIdle;
          w_dm_req_d   = 1'b0;
          w_valid_d    = 1'b1;
          w_regwrite_d = RegWrite_IN;
          w_wreg_d     = WriteRegister_IN;
          w_wdata_d    = MemRead_IN ? w_ld_data : w_res;
        end else if (w_timeout) begin
          w_state_d  = StIdle;
          w_dm_req_d = 1'b0;
          w_valid_d  = 1'b1;
          w_buserr_d = 1'b1;
          w_wreg_d   = WriteRegister_IN;
          w_wdata_d  = w_res;
        end else begin
          w_stall = 1'b1;
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wreg     <= '0;
      r_wdata    <= '0;
      r_addrerr  <= 1'b0;
      r_buserr   <= 1'b0;
      r_dm_req   <= 1'b0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_be    <= '0;
      r_dm_wdata <= '0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_valid    <= w_valid_d;
      r_regwrite <= w_regwrite_d;
      r_wreg     <= w_wreg_d;
      r_wdata    <= w_wdata_d;
      r_addrerr  <= w_addrerr_d;
      r_buserr   <= w_buserr_d;
      r_dm_req   <= w_dm_req_d;
      r_dm_we    <= w_dm_we_d;
      r_dm_addr  <= w_dm_addr_d;
      r_dm_be    <= w_dm_be_d;
      r_dm_wdata <= w_dm_wdata_d;
    end
  end

  assign Stall_OUT         = w_stall;
  assign Valid_OUT         = r_valid;
  assign RegWrite_OUT      = r_regwrite;
  assign WriteRegister_OUT = r_wreg;
  assign WriteData_OUT     = r_wdata;
  assign AddrErr_OUT       = r_addrerr;
  assign BusErr_OUT        = r_buserr;
  assign dm_req            = r_dm_req;
  assign dm_we             = r_dm_we;
  assign dm_addr           = r_dm_addr;
  assign dm_be             = r_dm_be;
  assign dm_wdata          = r_dm_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases, timeout, reset-in-BUSY and a
// randomized load/store mix checked against a byte-level reference model.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  localparam logic [5:0] OpLb   = 6'b100001;
  localparam logic [5:0] OpLbu  = 6'b101010;
  localparam logic [5:0] OpLh   = 6'b101011;
  localparam logic [5:0] OpLhu  = 6'b101100;
  localparam logic [5:0] OpLw   = 6'b111101;
  localparam logic [5:0] OpLl   = 6'b101000;
  localparam logic [5:0] OpLwc1 = 6'b110101;
  localparam logic [5:0] OpLwl  = 6'b101101;
  localparam logic [5:0] OpLwr  = 6'b101110;
  localparam logic [5:0] OpSb   = 6'b101111;
  localparam logic [5:0] OpSh   = 6'b110000;
  localparam logic [5:0] OpSw   = 6'b110001;
  localparam logic [5:0] OpSc   = 6'b110110;
  localparam logic [5:0] OpSwl  = 6'b110010;
  localparam logic [5:0] OpSwr  = 6'b110011;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Valid_IN;
  logic [5:0]  ALU_Control_IN;
  logic [31:0] ALU_result_IN;
  logic [31:0] MemWriteData_IN;
  logic [4:0]  WriteRegister_IN;
  logic        RegWrite_IN, MemRead_IN, MemWrite_IN;
  logic        Stall_OUT, Valid_OUT, RegWrite_OUT, AddrErr_OUT, BusErr_OUT;
  logic [4:0]  WriteRegister_OUT;
  logic [31:0] WriteData_OUT;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .Valid_IN(Valid_IN), .ALU_Control_IN(ALU_Control_IN),
    .ALU_result_IN(ALU_result_IN), .MemWriteData_IN(MemWriteData_IN),
    .WriteRegister_IN(WriteRegister_IN), .RegWrite_IN(RegWrite_IN), .MemRead_IN(MemRead_IN),
    .MemWrite_IN(MemWrite_IN), .Stall_OUT(Stall_OUT), .Valid_OUT(Valid_OUT),
    .RegWrite_OUT(RegWrite_OUT), .WriteRegister_OUT(WriteRegister_OUT),
    .WriteData_OUT(WriteData_OUT), .AddrErr_OUT(AddrErr_OUT), .BusErr_OUT(BusErr_OUT),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model (byte-level view of the rules) ----------------
  function automatic logic [7:0] lane(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  function automatic bit is_load(input logic [5:0] op);
    return op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLl, OpLwc1, OpLwl, OpLwr};
  endfunction

  function automatic bit is_misaligned(input logic [5:0] op, input int o);
    if (op inside {OpLh, OpLhu, OpSh}) return (o % 2) != 0;
    if (op inside {OpLw, OpLl, OpLwc1, OpSw, OpSc}) return o != 0;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input int o,
                                             input logic [31:0] rd, input logic [31:0] old);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    b = lane(rd, o);
    h = {lane(rd, o), lane(rd, (o + 1) % 4)};
    r = rd;
    case (op)
      OpLb:  r = {{24{b[7]}}, b};
      OpLbu: r = {24'h0, b};
      OpLh:  r = {{16{h[15]}}, h};
      OpLhu: r = {16'h0, h};
      OpLwl: for (int i = 0; i < 4; i++) r[31-8*i -: 8] = (i < 4 - o) ? lane(rd, o + i) : lane(old, i);
      OpLwr: for (int i = 0; i < 4; i++) r[31-8*i -: 8] = (i >= 3 - o) ? lane(rd, i - (3 - o)) : lane(old, i);
      default: r = rd;
    endcase
    return r;
  endfunction

  // Returns {be, wdata}; be bit (3-k) enables lane k.
  function automatic logic [35:0] model_store(input logic [5:0] op, input int o, input logic [31:0] rt);
    logic [3:0]  be;
    logic [31:0] d;
    be = 4'b1111;
    d  = rt;
    case (op)
      OpSb: begin be = '0; be[3-o] = 1'b1; d = {4{rt[7:0]}}; end
      OpSh: begin be = '0; be[3-o] = 1'b1; be[2-o] = 1'b1; d = {2{rt[15:0]}}; end
      OpSwl: begin
        be = '0; d = '0;
        for (int k = o; k < 4; k++) begin be[3-k] = 1'b1; d[31-8*k -: 8] = lane(rt, k - o); end
      end
      OpSwr: begin
        be = '0; d = '0;
        for (int k = 0; k <= o; k++) begin be[3-k] = 1'b1; d[31-8*k -: 8] = lane(rt, 3 - o + k); end
      end
      default: ;
    endcase
    return {be, d};
  endfunction

  // ---------------- driver: one pipeline slot, memory responder, observations ----------------
  int          obs_stalls;
  bit          obs_req, obs_done, obs_bubble_ok, obs_dm_stable;
  logic        obs_we, obs_valid, obs_rw, obs_ae, obs_bus, obs_req_after;
  logic [31:0] obs_addr, obs_wdata, obs_data;
  logic [3:0]  obs_be;
  logic [4:0]  obs_reg;

  // ack_on: BUSY cycle (1-based) in which dm_ack is returned; 0 = never.
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic rd_en, input logic wr_en, input logic rw, input logic [4:0] wreg,
                        input logic [31:0] rdata, input int ack_on);
    int busy_n;
    Valid_IN = 1'b1; ALU_Control_IN = op; ALU_result_IN = addr; MemWriteData_IN = rt;
    WriteRegister_IN = wreg; RegWrite_IN = rw; MemRead_IN = rd_en; MemWrite_IN = wr_en;
    obs_stalls = 0; obs_req = 0; obs_done = 0; obs_bubble_ok = 1; obs_dm_stable = 1; busy_n = 0;
    for (int i = 0; i < 64 && !obs_done; i++) begin
      @(negedge CLK);
      if (i > 0 && Valid_OUT !== 1'b0) obs_bubble_ok = 0;
      if (dm_req === 1'b1) begin
        busy_n++;
        if (busy_n == 1) begin
          obs_req = 1; obs_addr = dm_addr; obs_be = dm_be; obs_wdata = dm_wdata; obs_we = dm_we;
        end else if (dm_addr !== obs_addr || dm_be !== obs_be || dm_wdata !== obs_wdata ||
                     dm_we !== obs_we) begin
          obs_dm_stable = 0;
        end
        if (busy_n == ack_on) begin dm_ack = 1'b1; dm_rdata = rdata; end
      end
      #1;
      if (Stall_OUT === 1'b1) obs_stalls++;
      else obs_done = 1;
      @(posedge CLK); #1;
      dm_ack = 1'b0; dm_rdata = $urandom;
    end
    obs_valid = Valid_OUT; obs_rw = RegWrite_OUT; obs_ae = AddrErr_OUT; obs_bus = BusErr_OUT;
    obs_data = WriteData_OUT; obs_reg = WriteRegister_OUT; obs_req_after = dm_req;
    Valid_IN = 1'b0; MemRead_IN = 1'b0; MemWrite_IN = 1'b0; RegWrite_IN = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b1; Valid_IN = 0; ALU_Control_IN = '0; ALU_result_IN = 32'hDEAD_BEEF;
    MemWriteData_IN = '0; WriteRegister_IN = '0; RegWrite_IN = 0; MemRead_IN = 0; MemWrite_IN = 0;
    dm_ack = 0; dm_rdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if ({Valid_OUT, RegWrite_OUT, AddrErr_OUT, BusErr_OUT} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {Valid_OUT, RegWrite_OUT, AddrErr_OUT, BusErr_OUT});
    else n_pass++;
    n_checks++; if (WriteData_OUT !== 32'h0 || WriteRegister_OUT !== 5'h0)
      $display("FAIL reset_wb: got data %h reg %h want 0", WriteData_OUT, WriteRegister_OUT);
    else n_pass++;
    n_checks++; if ({dm_req, dm_we, dm_be} !== 6'b0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0)
      $display("FAIL reset_dm: got req %b we %b be %b addr %h wdata %h want 0",
               dm_req, dm_we, dm_be, dm_addr, dm_wdata);
    else n_pass++;
    RESET = 1'b0;
  endtask

  task automatic test_directed();
    // LB, offset 1, ack in first BUSY cycle
    run_op(OpLb, 32'h1001, 32'h0, 1, 0, 1, 5'd7, 32'h12F45678, 1);
    n_checks++; if (obs_addr !== 32'h1000 || obs_be !== 4'b1111 || obs_we !== 1'b0)
      $display("FAIL lb_req: got addr %h be %b we %b want 00001000 1111 0", obs_addr, obs_be, obs_we);
    else n_pass++;
    n_checks++; if (obs_data !== 32'hFFFFFFF4 || obs_valid !== 1'b1 || obs_reg !== 5'd7)
      $display("FAIL lb_data: got %h valid %b reg %0d want fffffff4 1 7", obs_data, obs_valid, obs_reg);
    else n_pass++;
    n_checks++; if (obs_stalls != 1 || !obs_bubble_ok)
      $display("FAIL lb_stall: got %0d stalls bubble_ok %0d want 1 1", obs_stalls, obs_bubble_ok);
    else n_pass++;
    n_checks++; if (obs_req_after !== 1'b0)
      $display("FAIL lb_req_drop: got dm_req %b want 0", obs_req_after);
    else n_pass++;
    // SWR, offset 2
    run_op(OpSwr, 32'h2002, 32'hAABBCCDD, 0, 1, 0, 5'd0, 32'h0, 2);
    n_checks++; if (obs_be !== 4'b1110 || obs_wdata !== 32'hBBCCDD00 || obs_we !== 1'b1)
      $display("FAIL swr: got be %b wdata %h we %b want 1110 bbccdd00 1", obs_be, obs_wdata, obs_we);
    else n_pass++;
    n_checks++; if (obs_data !== 32'h2002 || obs_stalls != 2)
      $display("FAIL swr_wb: got data %h stalls %0d want 00002002 2", obs_data, obs_stalls);
    else n_pass++;
    // LWL, offset 2
    run_op(OpLwl, 32'h3002, 32'h11223344, 1, 0, 1, 5'd9, 32'hA1B2C3D4, 1);
    n_checks++; if (obs_data !== 32'hC3D43344)
      $display("FAIL lwl: got %h want c3d43344", obs_data);
    else n_pass++;
    // misaligned LW
    run_op(OpLw, 32'h4002, 32'h0, 1, 0, 1, 5'd3, 32'h0, 1);
    n_checks++; if (obs_req || obs_stalls != 0)
      $display("FAIL lw_mis_req: got req %0d stalls %0d want 0 0", obs_req, obs_stalls);
    else n_pass++;
    n_checks++; if ({obs_valid, obs_ae, obs_rw, obs_bus} !== 4'b1100)
      $display("FAIL lw_mis_flags: got %b want 1100", {obs_valid, obs_ae, obs_rw, obs_bus});
    else n_pass++;
    @(posedge CLK); #1;
    n_checks++; if (AddrErr_OUT !== 1'b0 || Valid_OUT !== 1'b0)
      $display("FAIL lw_mis_pulse: got ae %b valid %b want 0 0", AddrErr_OUT, Valid_OUT);
    else n_pass++;
  endtask

  task automatic test_timeout();
    run_op(OpLw, 32'h6000, 32'h0, 1, 0, 1, 5'd4, 32'h55AA55AA, 0);
    n_checks++; if (obs_stalls != TIMEOUT || !obs_done)
      $display("FAIL to_stalls: got %0d done %0d want %0d 1", obs_stalls, obs_done, TIMEOUT);
    else n_pass++;
    n_checks++; if ({obs_valid, obs_bus, obs_rw, obs_ae, obs_req_after} !== 5'b11000)
      $display("FAIL to_flags: got %b want 11000", {obs_valid, obs_bus, obs_rw, obs_ae, obs_req_after});
    else n_pass++;
    n_checks++; if (!obs_dm_stable || !obs_bubble_ok)
      $display("FAIL to_hold: got stable %0d bubble_ok %0d want 1 1", obs_dm_stable, obs_bubble_ok);
    else n_pass++;
    @(posedge CLK); #1;
    n_checks++; if (BusErr_OUT !== 1'b0)
      $display("FAIL to_pulse: got %b want 0", BusErr_OUT);
    else n_pass++;
    // ack on the last counted BUSY cycle wins
    run_op(OpLw, 32'h6004, 32'h0, 1, 0, 1, 5'd4, 32'h55AA55AA, TIMEOUT);
    n_checks++; if (obs_stalls != TIMEOUT || obs_bus !== 1'b0 || obs_data !== 32'h55AA55AA || obs_rw !== 1'b1)
      $display("FAIL to_lastack: got stalls %0d bus %b data %h rw %b want %0d 0 55aa55aa 1",
               obs_stalls, obs_bus, obs_data, obs_rw, TIMEOUT);
    else n_pass++;
  endtask

  task automatic test_reset_busy();
    bit got;
    got = 0;
    Valid_IN = 1; ALU_Control_IN = OpSw; ALU_result_IN = 32'h5000; MemWriteData_IN = 32'h12345678;
    WriteRegister_IN = 5'd2; RegWrite_IN = 1; MemRead_IN = 0; MemWrite_IN = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CLK);
      if (dm_req === 1'b1) got = 1;
    end
    n_checks++; if (!got) $display("FAIL rb_req: got no dm_req want dm_req 1");
    else n_pass++;
    RESET = 1; Valid_IN = 0; MemWrite_IN = 0; RegWrite_IN = 0;
    @(posedge CLK); #1;
    n_checks++; if ({dm_req, dm_we, dm_be, Valid_OUT, RegWrite_OUT} !== 8'b0 || dm_addr !== 32'h0 ||
                    dm_wdata !== 32'h0 || WriteData_OUT !== 32'h0)
      $display("FAIL rb_clear: got req %b we %b be %b valid %b addr %h wdata %h want all 0",
               dm_req, dm_we, dm_be, Valid_OUT, dm_addr, dm_wdata);
    else n_pass++;
    RESET = 0; dm_ack = 1; dm_rdata = 32'hFFFF0000;
    @(posedge CLK); #1;
    dm_ack = 0;
    @(posedge CLK); #1;
    n_checks++; if ({Valid_OUT, dm_req, Stall_OUT, RegWrite_OUT} !== 4'b0)
      $display("FAIL rb_late_ack: got valid %b req %b stall %b rw %b want 0",
               Valid_OUT, dm_req, Stall_OUT, RegWrite_OUT);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0]  ops [17];
    logic [5:0]  op;
    logic [31:0] addr, rt, rd, exp_data;
    logic [35:0] st;
    logic [4:0]  wreg;
    logic        rw;
    bit          mem, ld, wr, mis;
    int          sel, lat, o;
    ops = '{OpLb, OpLbu, OpLh, OpLhu, OpLw, OpLl, OpLwc1, OpLwl, OpLwr,
            OpSb, OpSh, OpSw, OpSc, OpSwl, OpSwr, 6'b000000, 6'b100000};
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 16); op = ops[sel];
      mem = sel < 15; ld = mem && is_load(op); wr = mem && !ld;
      addr = $urandom; rt = $urandom; rd = $urandom; wreg = 5'($urandom); rw = 1'($urandom);
      lat = $urandom_range(1, 4); o = int'(addr[1:0]);
      mis = mem && is_misaligned(op, o);
      run_op(op, addr, rt, ld, wr, rw, wreg, rd, lat);
      n_checks++; if (obs_stalls != ((mem && !mis) ? lat : 0) || !obs_done)
        $display("FAIL rnd_stall op %b: got %0d want %0d", op, obs_stalls, (mem && !mis) ? lat : 0);
      else n_pass++;
      n_checks++; if ({obs_valid, obs_ae, obs_bus, obs_req_after} !== {1'b1, 1'(mis), 2'b00} ||
                      obs_req != (mem && !mis))
        $display("FAIL rnd_flags op %b o %0d: got v %b ae %b bus %b req %0d want 1 %0d 0 %0d",
                 op, o, obs_valid, obs_ae, obs_bus, obs_req, mis, mem && !mis);
      else n_pass++;
      n_checks++; if (obs_rw !== (mis ? 1'b0 : rw) || obs_reg !== wreg)
        $display("FAIL rnd_rw op %b: got rw %b reg %0d want %b %0d", op, obs_rw, obs_reg,
                 mis ? 1'b0 : rw, wreg);
      else n_pass++;
      if (!mis) begin
        exp_data = ld ? model_load(op, o, rd, rt) : addr;
        n_checks++; if (obs_data !== exp_data)
          $display("FAIL rnd_data op %b o %0d: got %h want %h", op, o, obs_data, exp_data);
        else n_pass++;
      end
      if (mem && !mis) begin
        st = wr ? model_store(op, o, rt) : {4'b1111, 32'h0};
        n_checks++; if (obs_addr !== {addr[31:2], 2'b00} || obs_we !== 1'(wr) || obs_be !== st[35:32])
          $display("FAIL rnd_req op %b o %0d: got addr %h we %b be %b want %h %0d %b",
                   op, o, obs_addr, obs_we, obs_be, {addr[31:2], 2'b00}, wr, st[35:32]);
        else n_pass++;
        if (wr) begin
          n_checks++; if (obs_wdata !== st[31:0])
            $display("FAIL rnd_wdata op %b o %0d: got %h want %h", op, o, obs_wdata, st[31:0]);
          else n_pass++;
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge CLK); #1;
        n_checks++; if ({Valid_OUT, AddrErr_OUT, BusErr_OUT} !== 3'b000)
          $display("FAIL rnd_idle: got %b want 000", {Valid_OUT, AddrErr_OUT, BusErr_OUT});
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
